// File: rtl/mod_goldilocks_inv_pkg.sv
// mod_goldilocks_inv_pkg: Goldilocks prime constants, inverter FSM states and the 128->64 bit modular reduction helper
package mod_goldilocks_inv_pkg;
  localparam logic [63:0] GOLDILOCKS_P = 64'hFFFFFFFF_00000001;
  localparam logic [63:0] INV_EXP = 64'hFFFFFFFE_FFFFFFFF;
  localparam int NB_INV_OP = 125;
  localparam logic [63:0] GL_EPS = 64'h00000000_FFFFFFFF;
  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} inv_state_e;
  function automatic logic [63:0] gl_reduce(input logic [127:0] prod);
    logic [63:0] lo, hh, t0, t1, s;
    logic [64:0] sum;
    lo = prod[63:0];
    hh = {32'd0, prod[127:96]};
    t0 = (lo < hh) ? lo - hh - GL_EPS : lo - hh;
    t1 = {prod[95:64], 32'd0} - {32'd0, prod[95:64]};
    sum = {1'b0, t0} + {1'b0, t1};
    s = sum[63:0] + (sum[64] ? GL_EPS : 64'd0);
    return (s >= GOLDILOCKS_P) ? s - GOLDILOCKS_P : s;
  endfunction
endpackage

// File: rtl/mod_goldilocks_inv_if.sv
// mod_goldilocks_inv_if: operand in (in_data/in_vld/in_rdy) and result out (out_data/out_err/out_vld/out_rdy) streams; master drives operands, slave is the inverter
interface mod_goldilocks_inv_if #(parameter int W = 64);
  logic [W-1:0] in_data;
  logic in_vld;
  logic in_rdy;
  logic [W-1:0] out_data;
  logic out_err;
  logic out_vld;
  logic out_rdy;
  modport master (output in_data, in_vld, out_rdy, input in_rdy, out_data, out_err, out_vld);
  modport slave (input in_data, in_vld, out_rdy, output in_rdy, out_data, out_err, out_vld);
endinterface

// File: rtl/goldilocks_mod_mult.sv
// goldilocks_mod_mult: valid-tagged MULT_LAT-stage a*b mod p pipeline, no backpressure; ports clk, a_rst, in_vld/in_a/in_b -> out_vld/out_data
module goldilocks_mod_mult
  import mod_goldilocks_inv_pkg::*;
#(
  parameter int MULT_LAT = 3
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        in_vld,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_vld,
  output logic [63:0] out_data
);
  logic [MULT_LAT-1:0] vld_q, vld_d;
  logic [63:0] data_q [MULT_LAT];
  logic [63:0] data_d [MULT_LAT];
  always_comb begin
    vld_d = '0;
    data_d = data_q;
    vld_d[0] = in_vld;
    data_d[0] = in_vld ? gl_reduce({64'd0, in_a} * {64'd0, in_b}) : data_q[0];
    for (int i = 1; i < MULT_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      vld_q <= '0;
      data_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      data_q <= data_d;
    end
  end
  assign out_vld = vld_q[MULT_LAT-1];
  assign out_data = data_q[MULT_LAT-1];
endmodule

// File: rtl/mod_goldilocks_inv.sv
// mod_goldilocks_inv: x^(p-2) mod p inverter by serial square-and-multiply; ports clk, a_rst, io (slave: in_data/in_vld/in_rdy, out_data/out_err/out_vld/out_rdy)
module mod_goldilocks_inv
  import mod_goldilocks_inv_pkg::*;
#(
  parameter int MOD_NTT_W = 64,
  parameter int MULT_LAT = 3
) (
  input logic clk,
  input logic a_rst,
  mod_goldilocks_inv_if.slave io
);
  localparam int WW = $clog2(MULT_LAT + 1);
  inv_state_e st_q, st_d;
  logic [5:0] bit_q, bit_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [MOD_NTT_W-1:0] acc_q, acc_d, base_q, base_d, x_red, res, mul_b, mul_out;
  logic zero_q, zero_d, rdy_q, rdy_d;
  logic accept, busy, done, issue, mul_vld;
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      st_q <= IDLE;
      bit_q <= '0;
      wait_q <= '0;
      acc_q <= '0;
      base_q <= '0;
      zero_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      bit_q <= bit_d;
      wait_q <= wait_d;
      acc_q <= acc_d;
      base_q <= base_d;
      zero_q <= zero_d;
      rdy_q <= rdy_d;
    end
  end
  always_comb begin
    accept = (st_q == IDLE) && rdy_q && io.in_vld;
    busy = (st_q == SQR) || (st_q == MUL);
    done = busy && mul_vld && (wait_q == WW'(MULT_LAT));
    x_red = (io.in_data >= GOLDILOCKS_P) ? io.in_data - GOLDILOCKS_P : io.in_data;
    res = done ? mul_out : acc_q;
    st_d = st_q;
    bit_d = bit_q;
    wait_d = wait_q;
    acc_d = acc_q;
    base_d = base_q;
    zero_d = zero_q;
    if (accept) begin
      st_d = SQR;
      bit_d = 6'd62;
      wait_d = '0;
      acc_d = x_red;
      base_d = x_red;
      zero_d = (x_red == '0);
    end else if (busy) begin
      wait_d = done ? WW'(1) : wait_q + WW'(1);
      if (done) begin
        acc_d = mul_out;
        st_d = (st_q == SQR && INV_EXP[bit_q]) ? MUL : (bit_q == '0) ? DONE : SQR;
        bit_d = (st_d == SQR) ? bit_q - 6'd1 : bit_q;
      end
    end else if (st_q == DONE && io.out_rdy) begin
      st_d = IDLE;
    end
    rdy_d = (st_d == IDLE);
  end
  // the next op is issued on the same edge the previous result lands, so operands are forwarded from the multiplier output
  always_comb begin
    issue = busy && ((wait_q == '0) || (done && st_d != DONE));
    mul_b = (st_d == MUL) ? base_q : res;
    io.in_rdy = rdy_q;
    io.out_vld = (st_q == DONE);
    io.out_data = acc_q;
    io.out_err = zero_q;
  end
  goldilocks_mod_mult #(.MULT_LAT(MULT_LAT)) u_mult (
    .clk(clk),
    .a_rst(a_rst),
    .in_vld(issue),
    .in_a(res),
    .in_b(mul_b),
    .out_vld(mul_vld),
    .out_data(mul_out)
  );
endmodule
